// File: rtl/ram_seq.sv
// RAM operation-bus arbiter/sequencer: shares the RAM between CPU microcode and a byte loader.
// Optional write readback verification is enabled with `define RAM_SEQ_VERIFY_EN.
module ram_seq #(
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 3
) (
  input  logic        main_clk,
  input  logic        initn,
  input  logic        cyc_end,
  input  logic        rd_stb,
  input  logic [3:0]  cpu_op,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic [3:0]  ram_x,
  input  logic [3:0]  ram_y,
  output logic [3:0]  op_n,
  output logic        ldr_sel,
  output logic [3:0]  a3n,
  output logic [3:0]  a4n,
  output logic [3:0]  z2,
  output logic [3:0]  z3,
  output logic [3:0]  sigma,
  output logic        cpu_wait,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        err
);

  localparam logic [3:0] OP_CA3  = 4'b1010;
  localparam logic [3:0] OP_ZPY  = 4'b0100;
  localparam logic [3:0] OP_ZPX  = 4'b1000;
  localparam logic [3:0] OP_IDLE = 4'b1111;
  localparam logic [CNT_W-1:0] LIM_C = CNT_W'(STARVE_LIM);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WR_HI, S_WR_LO, S_TAIL, S_RD_WAIT
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             we_r, we_s;
  logic [7:0]       wdata_r, wdata_s;
  logic [7:0]       rd_buf_r, rd_buf_s;
  logic             got_stb_r, got_stb_s;
  logic             miss_r, miss_s;
  logic             vfy_r, vfy_s;
  logic             done_s;
  logic [7:0]       fin_data_s;
  logic [3:0]       op_n_s, a3n_s, a4n_s, z2_s, z3_s, sigma_s;
  logic             ldr_sel_s, cpu_wait_s, ack_s, err_s;
  logic [7:0]       rdata_s;

  // Next-state and next-output logic; everything changes only on cyc_end except strobe capture.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    we_s       = we_r;
    wdata_s    = wdata_r;
    rd_buf_s   = rd_buf_r;
    got_stb_s  = got_stb_r;
    miss_s     = miss_r;
    vfy_s      = vfy_r;
    done_s     = 1'b0;
    fin_data_s = 8'h00;
    op_n_s     = op_n;
    ldr_sel_s  = ldr_sel;
    a3n_s      = a3n;
    a4n_s      = a4n;
    z2_s       = z2;
    z3_s       = z3;
    sigma_s    = sigma;
    cpu_wait_s = cpu_wait;
    ack_s      = 1'b0;
    rdata_s    = rdata;
    err_s      = err;

    if ((state_r == S_RD_WAIT) && rd_stb) begin
      got_stb_s = 1'b1;
      rd_buf_s  = {ram_y, ram_x};
    end else begin
      got_stb_s = got_stb_r;
    end

    if (cyc_end) begin
      case (state_r)
        S_IDLE: begin
          op_n_s = cpu_op;
          if (req) begin
            if ((cpu_op == OP_IDLE) || (cnt_r >= LIM_C)) begin
              state_s    = S_ADDR;
              op_n_s     = OP_CA3;
              ldr_sel_s  = 1'b1;
              cpu_wait_s = 1'b1;
              cnt_s      = '0;
              we_s       = we;
              wdata_s    = wdata;
              a3n_s      = ~addr[15:12];
              a4n_s      = ~addr[11:8];
              z2_s       = addr[7:4];
              z3_s       = addr[3:0];
              sigma_s    = we ? wdata[7:4] : 4'h0;
              vfy_s      = 1'b0;
            end else begin
              // Below the limit here, so the increment cannot overflow.
              cnt_s      = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
              cpu_wait_s = (cnt_s == LIM_C);
            end
          end else begin
            cnt_s      = '0;
            cpu_wait_s = 1'b0;
          end
        end
        S_ADDR: begin
          if (we_r && !vfy_r) begin
            state_s = S_WR_HI;
            op_n_s  = OP_ZPY;
            sigma_s = wdata_r[7:4];
          end else begin
            state_s   = S_RD_WAIT;
            op_n_s    = OP_IDLE;
            got_stb_s = 1'b0;
            miss_s    = 1'b0;
          end
        end
        S_WR_HI: begin
          state_s = S_WR_LO;
          op_n_s  = OP_ZPX;
          sigma_s = wdata_r[3:0];
        end
        S_WR_LO: begin
          state_s = S_TAIL;
          op_n_s  = OP_IDLE;
        end
        S_TAIL: begin
`ifdef RAM_SEQ_VERIFY_EN
          state_s = S_ADDR;
          op_n_s  = OP_CA3;
          vfy_s   = 1'b1;
`else
          done_s  = 1'b1;
`endif
        end
        S_RD_WAIT: begin
          if (got_stb_s) begin
            done_s     = 1'b1;
            fin_data_s = rd_buf_s;
          end else if (!miss_r) begin
            miss_s = 1'b1;
          end else begin
            done_s     = 1'b1;
            fin_data_s = 8'h00;
          end
        end
        default: begin
          state_s = S_IDLE;
          op_n_s  = OP_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    if (done_s) begin
      ack_s      = 1'b1;
      state_s    = S_IDLE;
      op_n_s     = OP_IDLE;
      ldr_sel_s  = 1'b0;
      cpu_wait_s = 1'b0;
      vfy_s      = 1'b0;
      if (!we_r) begin
        rdata_s = fin_data_s;
      end else begin
        rdata_s = rdata;
      end
`ifdef RAM_SEQ_VERIFY_EN
      if (vfy_r && (fin_data_s != wdata_r)) begin
        err_s = 1'b1;
      end else begin
        err_s = err;
      end
`endif
    end else begin
      ack_s = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge main_clk or negedge initn) begin
    if (!initn) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      we_r      <= 1'b0;
      wdata_r   <= 8'h00;
      rd_buf_r  <= 8'h00;
      got_stb_r <= 1'b0;
      miss_r    <= 1'b0;
      vfy_r     <= 1'b0;
      op_n      <= OP_IDLE;
      ldr_sel   <= 1'b0;
      a3n       <= 4'hF;
      a4n       <= 4'hF;
      z2        <= 4'h0;
      z3        <= 4'h0;
      sigma     <= 4'h0;
      cpu_wait  <= 1'b0;
      ack       <= 1'b0;
      rdata     <= 8'h00;
      err       <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      we_r      <= we_s;
      wdata_r   <= wdata_s;
      rd_buf_r  <= rd_buf_s;
      got_stb_r <= got_stb_s;
      miss_r    <= miss_s;
      vfy_r     <= vfy_s;
      op_n      <= op_n_s;
      ldr_sel   <= ldr_sel_s;
      a3n       <= a3n_s;
      a4n       <= a4n_s;
      z2        <= z2_s;
      z3        <= z3_s;
      sigma     <= sigma_s;
      cpu_wait  <= cpu_wait_s;
      ack       <= ack_s;
      rdata     <= rdata_s;
      err       <= err_s;
    end
  end

endmodule

// File: tb/tb_ram_seq.sv
// Table-driven bench for ram_seq: one vector row per machine cycle, plus reset and verify sequences.
module tb_ram_seq;

  logic        main_clk = 1'b0;
  logic        initn = 1'b0;
  logic        cyc_end = 1'b0;
  logic        rd_stb = 1'b0;
  logic [3:0]  cpu_op = 4'hF;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic [3:0]  ram_x = 4'h0;
  logic [3:0]  ram_y = 4'h0;
  logic [3:0]  op_n, a3n, a4n, z2, z3, sigma;
  logic        ldr_sel, cpu_wait, ack, err;
  logic [7:0]  rdata;

  int checks = 0;
  int errors = 0;

  ram_seq #(.STARVE_LIM(4), .CNT_W(3)) dut (
    .main_clk(main_clk), .initn(initn), .cyc_end(cyc_end), .rd_stb(rd_stb),
    .cpu_op(cpu_op), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ram_x(ram_x), .ram_y(ram_y), .op_n(op_n), .ldr_sel(ldr_sel),
    .a3n(a3n), .a4n(a4n), .z2(z2), .z3(z3), .sigma(sigma),
    .cpu_wait(cpu_wait), .ack(ack), .rdata(rdata), .err(err)
  );

  always #5 main_clk = ~main_clk;

  typedef struct {
    logic [3:0]  cpu_op;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        stb;
    logic [7:0]  rbyte;
    logic [3:0]  e_op;
    logic        e_sel;
    logic        e_wait;
    logic        e_ack;
    logic [3:0]  e_sigma;
    logic [7:0]  e_rdata;
    logic [15:0] e_bus;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] c, input logic r, input logic w, input logic [15:0] a,
                     input logic [7:0] d, input logic s, input logic [7:0] rb,
                     input logic [3:0] eo, input logic es, input logic ew, input logic ea,
                     input logic [3:0] esg, input logic [7:0] erd, input logic [15:0] eb);
    vec_t v;
    v.cpu_op = c; v.req = r; v.we = w; v.addr = a; v.wdata = d; v.stb = s; v.rbyte = rb;
    v.e_op = eo; v.e_sel = es; v.e_wait = ew; v.e_ack = ea; v.e_sigma = esg;
    v.e_rdata = erd; v.e_bus = eb;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One machine cycle of four clocks; cyc_end on the last, optional rd_stb on the second.
  task automatic mcyc(input logic stb, input logic [7:0] rb);
    for (int i = 0; i < 4; i++) begin
      @(negedge main_clk);
      rd_stb  = stb && (i == 1);
      ram_y   = rb[7:4];
      ram_x   = rb[3:0];
      cyc_end = (i == 3);
    end
    @(negedge main_clk);
    rd_stb  = 1'b0;
    cyc_end = 1'b0;
  endtask

  initial begin
    // write 0xA5 @0x1234, req dropped mid-transaction
    add(4'h3, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 4'h3, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 16'hFF00);
    add(4'hF, 1'b1, 1'b1, 16'h1234, 8'hA5, 1'b0, 8'h00, 4'hA, 1'b1, 1'b1, 1'b0, 4'hA, 8'h00, 16'hED34);
    add(4'h6, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 4'h4, 1'b1, 1'b1, 1'b0, 4'hA, 8'h00, 16'hED34);
    add(4'h6, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 4'h8, 1'b1, 1'b1, 1'b0, 4'h5, 8'h00, 16'hED34);
    add(4'h6, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 4'hF, 1'b1, 1'b1, 1'b0, 4'h5, 8'h00, 16'hED34);
`ifdef RAM_SEQ_VERIFY_EN
    add(4'h6, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 4'hA, 1'b1, 1'b1, 1'b0, 4'h5, 8'h00, 16'hED34);
    add(4'h6, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 4'hF, 1'b1, 1'b1, 1'b0, 4'h5, 8'h00, 16'hED34);
`endif
    add(4'h6, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hA5, 4'hF, 1'b0, 1'b0, 1'b1, 4'h5, 8'h00, 16'hED34);
    add(4'h6, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 4'h6, 1'b0, 1'b0, 1'b0, 4'h5, 8'h00, 16'hED34);
    // read @0xABCD returning 0x5A
    add(4'hF, 1'b1, 1'b0, 16'hABCD, 8'h00, 1'b0, 8'h00, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 16'h54CD);
    add(4'hF, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 4'hF, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 16'h54CD);
    add(4'hF, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h5A, 4'hF, 1'b0, 1'b0, 1'b1, 4'h0, 8'h5A, 16'h54CD);
    // read with no strobe: ack on third boundary, rdata 0
    add(4'hF, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0, 8'h5A, 16'hFF00);
    add(4'hF, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 4'hF, 1'b1, 1'b1, 1'b0, 4'h0, 8'h5A, 16'hFF00);
    add(4'hF, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 4'hF, 1'b1, 1'b1, 1'b0, 4'h0, 8'h5A, 16'hFF00);
    add(4'hF, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 4'hF, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 16'hFF00);
    // starvation: CPU busy with 0110, req held
    add(4'h6, 1'b1, 1'b1, 16'h00FF, 8'h0F, 1'b0, 8'h00, 4'h6, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 16'hFF00);
    add(4'h6, 1'b1, 1'b1, 16'h00FF, 8'h0F, 1'b0, 8'h00, 4'h6, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 16'hFF00);
    add(4'h6, 1'b1, 1'b1, 16'h00FF, 8'h0F, 1'b0, 8'h00, 4'h6, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 16'hFF00);
    add(4'h6, 1'b1, 1'b1, 16'h00FF, 8'h0F, 1'b0, 8'h00, 4'h6, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 16'hFF00);
    add(4'h6, 1'b1, 1'b1, 16'h00FF, 8'h0F, 1'b0, 8'h00, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 16'hFFFF);
    add(4'h6, 1'b1, 1'b1, 16'h00FF, 8'h0F, 1'b0, 8'h00, 4'h4, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 16'hFFFF);
    add(4'h6, 1'b1, 1'b1, 16'h00FF, 8'h0F, 1'b0, 8'h00, 4'h8, 1'b1, 1'b1, 1'b0, 4'hF, 8'h00, 16'hFFFF);
    add(4'h6, 1'b1, 1'b1, 16'h00FF, 8'h0F, 1'b0, 8'h00, 4'hF, 1'b1, 1'b1, 1'b0, 4'hF, 8'h00, 16'hFFFF);
`ifdef RAM_SEQ_VERIFY_EN
    add(4'h6, 1'b1, 1'b1, 16'h00FF, 8'h0F, 1'b0, 8'h00, 4'hA, 1'b1, 1'b1, 1'b0, 4'hF, 8'h00, 16'hFFFF);
    add(4'h6, 1'b1, 1'b1, 16'h00FF, 8'h0F, 1'b0, 8'h00, 4'hF, 1'b1, 1'b1, 1'b0, 4'hF, 8'h00, 16'hFFFF);
`endif
    add(4'h6, 1'b1, 1'b1, 16'h00FF, 8'h0F, 1'b1, 8'h0F, 4'hF, 1'b0, 1'b0, 1'b1, 4'hF, 8'h00, 16'hFFFF);
    // req held through ack: next boundary grants a read @0x5555
    add(4'hF, 1'b1, 1'b0, 16'h5555, 8'h00, 1'b0, 8'h00, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 16'hAA55);
    add(4'hF, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 4'hF, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 16'hAA55);
    add(4'hF, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h3C, 4'hF, 1'b0, 1'b0, 1'b1, 4'h0, 8'h3C, 16'hAA55);

    repeat (3) @(negedge main_clk);
    check("rst_op_n", {12'h0, op_n}, 16'h000F);
    check("rst_ctrl", {12'h0, ldr_sel, cpu_wait, ack, err}, 16'h0000);
    check("rst_rdata", {8'h0, rdata}, 16'h0000);
    check("rst_bus", {a3n, a4n, z2, z3}, 16'hFF00);
    check("rst_sigma", {12'h0, sigma}, 16'h0000);
    initn = 1'b1;

    foreach (tbl[k]) begin
      cpu_op = tbl[k].cpu_op;
      req    = tbl[k].req;
      we     = tbl[k].we;
      addr   = tbl[k].addr;
      wdata  = tbl[k].wdata;
      mcyc(tbl[k].stb, tbl[k].rbyte);
      check($sformatf("row%0d_op_n", k), {12'h0, op_n}, {12'h0, tbl[k].e_op});
      check($sformatf("row%0d_sel_wait_ack", k), {13'h0, ldr_sel, cpu_wait, ack},
            {13'h0, tbl[k].e_sel, tbl[k].e_wait, tbl[k].e_ack});
      check($sformatf("row%0d_sigma", k), {12'h0, sigma}, {12'h0, tbl[k].e_sigma});
      check($sformatf("row%0d_rdata", k), {8'h0, rdata}, {8'h0, tbl[k].e_rdata});
      check($sformatf("row%0d_bus", k), {a3n, a4n, z2, z3}, tbl[k].e_bus);
    end
    check("err_after_table", {15'h0, err}, 16'h0000);

    // reset asserted during WR_HI
    cpu_op = 4'hF; req = 1'b1; we = 1'b1; addr = 16'h4321; wdata = 8'h99;
    mcyc(1'b0, 8'h00);
    req = 1'b0;
    mcyc(1'b0, 8'h00);
    check("mid_wr_hi_op", {12'h0, op_n}, 16'h0004);
    @(negedge main_clk);
    initn = 1'b0;
    #1;
    check("mid_rst_op", {12'h0, op_n}, 16'h000F);
    check("mid_rst_ctrl", {13'h0, ldr_sel, cpu_wait, ack}, 16'h0000);
    @(negedge main_clk);
    initn = 1'b1;
    cpu_op = 4'h3;
    for (int n = 0; n < 4; n++) begin
      mcyc(1'b0, 8'h00);
      check("post_rst_follow", {12'h0, op_n}, 16'h0003);
      check("post_rst_no_ack", {13'h0, ldr_sel, cpu_wait, ack}, 16'h0000);
    end

`ifdef RAM_SEQ_VERIFY_EN
    // bad readback sets err; a later clean write leaves it set
    for (int pass = 0; pass < 2; pass++) begin
      cpu_op = 4'hF; req = 1'b1; we = 1'b1; addr = 16'h0102; wdata = 8'h3C;
      mcyc(1'b0, 8'h00);
      req = 1'b0;
      for (int n = 0; n < 5; n++) begin
        mcyc(1'b0, 8'h00);
        check("vfy_no_early_ack", {15'h0, ack}, 16'h0000);
      end
      mcyc(1'b1, (pass == 0) ? 8'h3D : 8'h3C);
      check("vfy_ack", {15'h0, ack}, 16'h0001);
      check("vfy_err", {15'h0, err}, 16'h0001);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_seq.md
Name: ram_seq

Overview:
- Arbiter and sequencer for the RAM subsystem's operation bus (8w8..8w15 codes on -E20..-E17).
- Shares the RAM between the CPU microcode and a byte-wide loader/debug port.
- Converts one loader byte request into the multi-machine-cycle code sequence the RAM needs: CA3 address set, then either Y/X nibble writes or a deferred X/Y read.
- Sits between the microcode decoder and the RAM; the top level muxes address/data sources with ldr_sel.

Parameters:
- STARVE_LIM, 4, machine-cycle boundaries a pending loader request may wait behind CPU RAM ops before the CPU is forced to wait.
- CNT_W, 3, width of the starvation counter; must hold STARVE_LIM.

Ports:
- main_clk  in  1  system clock.
- initn  in  1  asynchronous active-low reset.
- cyc_end  in  1  one-clock pulse at the end of each machine cycle (tn10 rise); all state transitions happen on it.
- rd_stb  in  1  one-clock pulse when X/Y outputs of RAM are valid (tn5 rise).
- cpu_op  in  4  CPU requested code {-E20,-E19,-E18,-E17}; 4'b1111 = no RAM op.
- req  in  1  loader request level.
- we  in  1  loader write (1) / read (0); sampled at grant.
- addr  in  16  loader virtual address; sampled at grant.
- wdata  in  8  loader write byte; sampled at grant.
- ram_x  in  4  RAM X nibble (low).
- ram_y  in  4  RAM Y nibble (high).
- op_n  out  4  code driven to -E20..-E17.
- ldr_sel  out  1  1 = RAM address/data sources come from the loader fields below.
- a3n  out  4  ~addr[15:12].
- a4n  out  4  ~addr[11:8].
- z2  out  4  addr[7:4].
- z3  out  4  addr[3:0].
- sigma  out  4  write nibble.
- cpu_wait  out  1  CPU microcode must repeat its current cycle.
- ack  out  1  one-clock pulse on loader transaction completion.
- rdata  out  8  {Y,X} read byte; valid from ack and held until the next ack.
- err  out  1  verify mismatch (optional feature only); otherwise constant 0.

Behaviour:
- Reset: all outputs registered and reset asynchronously.
  - State IDLE.
  - op_n=4'b1111; ldr_sel=0; cpu_wait=0; ack=0; rdata=0; err=0.
  - a3n=a4n=4'hF; z2=z3=sigma=0; starvation counter=0.
- Codes: CA3=1010, ZPY=0100, ZPX=1000, idle=1111.
- In IDLE, op_n follows cpu_op, registered: it updates on the clock after cyc_end and holds for the whole next machine cycle.
- Arbitration is evaluated at cyc_end in IDLE with req=1:
  - Grant if cpu_op==1111, or the counter has reached STARVE_LIM.
  - Otherwise increment the counter (saturating). When it equals STARVE_LIM, assert cpu_wait for the following cycle.
  - Grant latches addr/we/wdata, sets ldr_sel=1 and cpu_wait=1, and clears the counter.
- Write path. States advance one per cyc_end:
  - ADDR: op_n=CA3, sigma=wdata[7:4].
  - WR_HI: op_n=ZPY.
  - WR_LO: op_n=ZPX, sigma=wdata[3:0].
  - TAIL: op_n=1111.
  - At the TAIL cyc_end, pulse ack and return to IDLE with ldr_sel=0 and cpu_wait=0.
- Read path:
  - ADDR: op_n=CA3.
  - RD_WAIT: op_n=1111; at rd_stb, capture rdata={ram_y,ram_x}.
  - At the RD_WAIT cyc_end, pulse ack and return to IDLE.
  - If no rd_stb occurred in RD_WAIT, stay in RD_WAIT for one more cycle. Two missed strobes: ack anyway, with rdata=8'h00.
- req deasserted mid-transaction: the transaction completes and ack still pulses. A new grant requires req high at a later cyc_end; a level req held through ack starts a new transaction.
- cpu_op is ignored (not queued) while ldr_sel=1; the CPU re-issues it under cpu_wait.
- Reset mid-transaction: return to IDLE immediately with reset values; no ack.
- Address wrap: none internally; the address is passed through verbatim.

Optional Feature:
- RAM_SEQ_VERIFY_EN: after a write's TAIL, run the read path (ADDR, RD_WAIT) on the same address and compare with wdata.
  - On mismatch, set err (sticky until reset), then ack.
  - Write latency grows from 4 to 6 machine cycles.
- Without the macro: writes take 4 cycles and err is tied to 0.

Test Plan:
- Write 0xA5 to addr 0x1234 with cpu_op idle -> op_n sequence 1010,0100,1000,1111; sigma A then 5; a3n=E, a4n=D, z2=3, z3=4; ack after 4 cyc_end.
- Read with ram_y=5, ram_x=A at rd_stb -> op_n 1010,1111; rdata=0x5A at ack after 2 cyc_end.
- req held while cpu_op=0110 continuously, STARVE_LIM=4 -> cpu_wait at cycle 4, grant at 5th boundary, CPU code absent during transaction.
- initn low during WR_HI -> op_n=1111, ldr_sel=0, cpu_wait=0 immediately; no ack; idle follows cpu_op afterwards.
- Read with no rd_stb for 2 cycles -> ack at third boundary with rdata=0x00.
- With RAM_SEQ_VERIFY_EN: write 0x3C, bench returns 0x3D on readback -> err=1, ack after 6 cycles; err remains set through the next clean write.
